ascon_sbox_loader: RTL and testbench
====================================

Name: ascon_sbox_loader

Overview:
- Register-interface initiator that programs the ASCON SBox register file (8 row registers, 4 × 5-bit entries each) after reset or on request.
- Drives reg_req_t transactions into the SBox register bus, replacing software-driven table setup. The SBox LUT datapath then reads the programmed entries.
- Table source is selectable: the built-in standard ASCON SBox, or a 32-entry table supplied on a port.

Parameters:
- BASE_ADDR, 32'h0, byte address of SBox row 0; row r is at BASE_ADDR + 4*r.
- NUM_ROWS, 8, number of row registers to program; fixed at 8 for ASCON, entries per row fixed at 4.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for reg_rsp_i.ready per transaction before error; range 1..65535.
- AUTO_START, 1'b1, when 1 a load starts on the first cycle after reset deassertion without start_i.

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  reset, asynchronous, active-low
- start_i  input  1  single-cycle pulse; request a full table load
- table_sel_i  input  1  0 = built-in ASCON SBox, 1 = table_i; sampled on the start cycle
- table_i  input  32x5 (logic [31:0][4:0])  user SBox table, entry i = S(i); sampled on the start cycle
- reg_req_o  output  reg_req_t  register bus request (addr, write, wdata, wstrb, valid)
- reg_rsp_i  input  reg_rsp_t  register bus response (rdata, error, ready)
- busy_o  output  1  load in progress
- done_o  output  1  one-cycle pulse when a load completes, with or without error
- error_o  output  1  sticky; a bus error or timeout occurred in the last load
- err_row_o  output  3  row index of the first failing transaction

Behaviour:
- Reset values: reg_req_o all zero (valid=0), busy_o=0, done_o=0, error_o=0, err_row_o=0. FSM is in IDLE.
- Row word packing: entry k of row r is bits [8k+4:8k], and the other bits are 0. wstrb=4'hF, write=1, addr=BASE_ADDR+4*r.
  - Built-in table: row0=32'h141F0B04, row1=32'h0209151A, row7=32'h170F0A16.
  - The remaining rows follow the ASCON SBox {04,0b,1f,14,1a,15,09,02,1b,05,08,12,1d,03,06,1c,1e,13,07,0e,00,0d,11,18,10,0c,01,19,16,0a,0f,17}.
- Table snapshot: the selected table is captured into internal registers on the start cycle. table_i changes during a load have no effect.
- FSM states:
  - IDLE: on start_i, or on the first post-reset cycle when AUTO_START=1, go to WRITE. Capture the table, row=0, clear error_o and err_row_o, busy_o=1.
  - WRITE: hold valid=1 with stable addr/wdata until ready=1. The handshake completes in the cycle valid&&ready.
    - If rsp.error=1, set error_o and latch err_row_o.
    - If row==NUM_ROWS-1, go to CHECK (feature enabled) or FIN. Otherwise increment row, and the next request is issued the following cycle (valid stays high, back-to-back allowed).
  - Timeout: a cycle counter resets at each new request. If it reaches TIMEOUT_CYCLES without ready, set error_o, latch err_row_o, drop valid and go to FIN. The remaining rows are not written.
  - FIN: valid=0, busy_o=0, done_o=1 for exactly one cycle, then IDLE.
- Only the first error updates err_row_o. Loading continues after a bus error, but stops after a timeout.
- start_i while busy_o=1 is ignored. start_i in the same cycle as the done_o pulse is also ignored; it is accepted from IDLE only.
- Reset mid-load: all state returns to reset values immediately. A partially written table is left as is. With AUTO_START=1 a fresh load begins after reset release.
- Latency: with zero-wait-state ready, a load takes 1 (IDLE→WRITE) + 8 write cycles, and done_o asserts on the cycle after the last handshake.

Optional Feature:
- Macro: ASCON_SBOX_LOADER_VERIFY_EN.
- Defined: after the last write, the CHECK state issues 8 reads (write=0, wstrb=0) at the same addresses. It compares rsp.rdata masked with 32'h1F1F1F1F against the expected word.
  - A mismatch, read error or timeout sets error_o and err_row_o (first failure only). Then go to FIN.
  - With zero-wait-state ready, done_o arrives 8 cycles later.
- Undefined: there is no CHECK state and rdata is ignored.

Test Plan:
- Reset release, AUTO_START=1, ready tied 1 -> 8 writes at BASE_ADDR+0..+28; row0 wdata=32'h141F0B04, row7=32'h170F0A16; done_o pulses once; error_o=0.
- table_sel_i=1, table_i[i]=i, start_i pulse -> row0 wdata=32'h03020100, row7=32'h1F1E1D1C; table_i changed mid-load does not alter later rows.
- Random ready stalls 0-5 cycles -> addr/wdata stable while valid&&!ready; exactly 8 handshakes; busy_o high throughout.
- rsp.error=1 on row 3 and on row 5 -> all 8 rows written; error_o=1; err_row_o=3.
- ready held low on row 2, TIMEOUT_CYCLES=16 -> valid drops after 16 cycles; error_o=1; err_row_o=2; rows 3-7 not written; rst_n_i low mid-load returns all outputs to 0 asynchronously.
- VERIFY_EN defined, bus model returns row 4 rdata=32'h0 -> error_o=1, err_row_o=4; with a correct model, error_o=0 after 16 handshakes.

Source files
------------

// File: rtl/ascon_sbox_loader.sv
// ascon_sbox_loader
//   Register-bus initiator that programs the ASCON SBox register file
//   (8 row registers, 4 x 5-bit entries per row) after reset or on request.
//   Entry k of row r sits in bits [8k+4:8k] of the row word; other bits are 0.
//
// Ports
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   start_i      one-cycle pulse requesting a full table load (accepted in IDLE only)
//   table_sel_i  0 = built-in ASCON SBox, 1 = table_i (sampled on the start cycle)
//   table_i      user table, entry i = S(i) (sampled on the start cycle)
//   reg_req_o    register bus request (addr, write, wdata, wstrb, valid)
//   reg_rsp_i    register bus response (rdata, error, ready)
//   busy_o       load in progress
//   done_o       one-cycle pulse when a load finishes (with or without error)
//   error_o      sticky error flag for the last load
//   err_row_o    row index of the first failing transaction
//
// Optional feature
//   Define ASCON_SBOX_LOADER_VERIFY_EN to read all rows back after the writes
//   and compare them (masked to the entry bits) against the loaded table.

package ascon_sbox_loader_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

module ascon_sbox_loader
    import ascon_sbox_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          NUM_ROWS       = 8,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic        AUTO_START     = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             table_sel_i,
    input  logic [31:0][4:0] table_i,
    output reg_req_t         reg_req_o,
    input  reg_rsp_t         reg_rsp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [2:0]       err_row_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CHECK = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam logic [2:0]  LAST_ROW = 3'(NUM_ROWS - 1);
    // Counter value at which the current transaction has waited TIMEOUT_CYCLES cycles.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
`ifdef ASCON_SBOX_LOADER_VERIFY_EN
    localparam logic [31:0] ENTRY_MASK = 32'h1F1F_1F1F;
`endif

    // Standard ASCON 5-bit SBox.
    function automatic logic [4:0] sbox_entry(input logic [4:0] idx);
        case (idx)
            5'd0:  return 5'h04;
            5'd1:  return 5'h0B;
            5'd2:  return 5'h1F;
            5'd3:  return 5'h14;
            5'd4:  return 5'h1A;
            5'd5:  return 5'h15;
            5'd6:  return 5'h09;
            5'd7:  return 5'h02;
            5'd8:  return 5'h1B;
            5'd9:  return 5'h05;
            5'd10: return 5'h08;
            5'd11: return 5'h12;
            5'd12: return 5'h1D;
            5'd13: return 5'h03;
            5'd14: return 5'h06;
            5'd15: return 5'h1C;
            5'd16: return 5'h1E;
            5'd17: return 5'h13;
            5'd18: return 5'h07;
            5'd19: return 5'h0E;
            5'd20: return 5'h00;
            5'd21: return 5'h0D;
            5'd22: return 5'h11;
            5'd23: return 5'h18;
            5'd24: return 5'h10;
            5'd25: return 5'h0C;
            5'd26: return 5'h01;
            5'd27: return 5'h19;
            5'd28: return 5'h16;
            5'd29: return 5'h0A;
            5'd30: return 5'h0F;
            5'd31: return 5'h17;
            default: return 5'h00;
        endcase
    endfunction

    // Row word: four entries, one per byte lane, upper 3 bits of each lane zero.
    function automatic logic [31:0] pack_row(input logic [31:0][4:0] tbl, input logic [2:0] row);
        return {3'b000, tbl[{row, 2'd3}], 3'b000, tbl[{row, 2'd2}],
                3'b000, tbl[{row, 2'd1}], 3'b000, tbl[{row, 2'd0}]};
    endfunction

    function automatic logic [31:0] row_addr(input logic [2:0] row);
        return BASE_ADDR + {27'd0, row, 2'b00};
    endfunction

    function automatic reg_req_t write_req(input logic [2:0] row, input logic [31:0] word);
        reg_req_t req;
        req.addr  = row_addr(row);
        req.write = 1'b1;
        req.wdata = word;
        req.wstrb = 4'hF;
        req.valid = 1'b1;
        return req;
    endfunction

`ifdef ASCON_SBOX_LOADER_VERIFY_EN
    function automatic reg_req_t read_req(input logic [2:0] row);
        reg_req_t req;
        req.addr  = row_addr(row);
        req.write = 1'b0;
        req.wdata = 32'h0000_0000;
        req.wstrb = 4'h0;
        req.valid = 1'b1;
        return req;
    endfunction
`endif

    state_t           state_r;
    reg_req_t         req_r;
    logic [2:0]       row_r;
    logic [31:0][4:0] tbl_r;
    logic [15:0]      tmo_cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             error_r;
    logic [2:0]       err_row_r;
    logic             auto_pend_r;

    logic [31:0][4:0] builtin_tbl_s;
    logic [31:0][4:0] sel_tbl_s;
    logic             hs_s;
    logic [2:0]       next_row_s;

    // Built-in table expanded into the same layout as table_i.
    always_comb begin
        builtin_tbl_s = '0;
        for (int i = 0; i < 32; i++) begin
            builtin_tbl_s[i] = sbox_entry(5'(i));
        end
    end

    // Table source chosen on the start cycle.
    always_comb begin
        if (table_sel_i) begin
            sel_tbl_s = table_i;
        end else begin
            sel_tbl_s = builtin_tbl_s;
        end
    end

    assign hs_s       = req_r.valid & reg_rsp_i.ready;
    assign next_row_s = row_r + 3'd1;

`ifndef ASCON_SBOX_LOADER_VERIFY_EN
    // Read data is only consumed by the read-back check.
    logic rdata_unused_s;
    assign rdata_unused_s = ^reg_rsp_i.rdata;
`endif

    // Load sequencer: snapshot, row writes (optional read-back), completion pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= ST_IDLE;
            req_r       <= '0;
            row_r       <= 3'd0;
            tbl_r       <= '0;
            tmo_cnt_r   <= 16'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            err_row_r   <= 3'd0;
            auto_pend_r <= AUTO_START;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start_i || auto_pend_r) begin
                        auto_pend_r <= 1'b0;
                        tbl_r       <= sel_tbl_s;
                        row_r       <= 3'd0;
                        error_r     <= 1'b0;
                        err_row_r   <= 3'd0;
                        busy_r      <= 1'b1;
                        tmo_cnt_r   <= 16'd0;
                        // First word comes from the live selection: the snapshot lands this same edge.
                        req_r       <= write_req(3'd0, pack_row(sel_tbl_s, 3'd0));
                        state_r     <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (hs_s) begin
                        if (reg_rsp_i.error && !error_r) begin
                            error_r   <= 1'b1;
                            err_row_r <= row_r;
                        end
                        tmo_cnt_r <= 16'd0;
                        if (row_r == LAST_ROW) begin
`ifdef ASCON_SBOX_LOADER_VERIFY_EN
                            row_r   <= 3'd0;
                            req_r   <= read_req(3'd0);
                            state_r <= ST_CHECK;
`else
                            req_r   <= '0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_FIN;
`endif
                        end else begin
                            row_r <= next_row_s;
                            req_r <= write_req(next_row_s, pack_row(tbl_r, next_row_s));
                        end
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        // Timeout abandons the remaining rows.
                        if (!error_r) begin
                            error_r   <= 1'b1;
                            err_row_r <= row_r;
                        end
                        req_r   <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_FIN;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 16'd1;
                    end
                end

`ifdef ASCON_SBOX_LOADER_VERIFY_EN
                ST_CHECK: begin
                    if (hs_s) begin
                        if ((reg_rsp_i.error ||
                             ((reg_rsp_i.rdata & ENTRY_MASK) != pack_row(tbl_r, row_r))) && !error_r) begin
                            error_r   <= 1'b1;
                            err_row_r <= row_r;
                        end
                        tmo_cnt_r <= 16'd0;
                        if (row_r == LAST_ROW) begin
                            req_r   <= '0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_FIN;
                        end else begin
                            row_r <= next_row_s;
                            req_r <= read_req(next_row_s);
                        end
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        if (!error_r) begin
                            error_r   <= 1'b1;
                            err_row_r <= row_r;
                        end
                        req_r   <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_FIN;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 16'd1;
                    end
                end
`endif

                ST_FIN: begin
                    // start_i is not looked at here, so a start during done_o is dropped.
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    req_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign reg_req_o = req_r;
    assign busy_o    = busy_r;
    assign done_o    = done_r;
    assign error_o   = error_r;
    assign err_row_o = err_row_r;

endmodule

// File: tb/tb_ascon_sbox_loader.sv
// Self-checking bench for ascon_sbox_loader: a behavioural bus slave with
// random stalls / injected errors / a hanging row, a table-level reference
// model, a vector table of load scenarios and a few directed sequences.
module tb_ascon_sbox_loader;
    import ascon_sbox_loader_pkg::*;

    localparam logic [31:0] TB_BASE = 32'h0000_0040;
    localparam int          TB_TMO  = 16;
`ifdef ASCON_SBOX_LOADER_VERIFY_EN
    localparam int          N_READS = 8;
`else
    localparam int          N_READS = 0;
`endif

    logic             clk_i       = 1'b0;
    logic             rst_n_i     = 1'b0;
    logic             start_i     = 1'b0;
    logic             table_sel_i = 1'b0;
    logic [31:0][4:0] table_i     = '0;
    reg_req_t         req;
    reg_rsp_t         rsp         = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
    logic             busy_o;
    logic             done_o;
    logic             error_o;
    logic [2:0]       err_row_o;

    ascon_sbox_loader #(
        .BASE_ADDR      (TB_BASE),
        .NUM_ROWS       (8),
        .TIMEOUT_CYCLES (TB_TMO),
        .AUTO_START     (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .table_sel_i (table_sel_i),
        .table_i     (table_i),
        .reg_req_o   (req),
        .reg_rsp_i   (rsp),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .err_row_o   (err_row_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: ASCON SBox values and the table the current load should use.
    int sbox_ref[32] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                         30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};
    int model_tbl[32];

    // Bus model state.
    reg_req_t    hs_q[$];
    logic [31:0] mem[8];
    reg_req_t    p_req = '0;
    logic        p_ready = 1'b0;
    int          stall_left = 0;
    bit          stalls_en = 1'b0;
    logic [7:0]  err_mask = 8'h00;
    int          hang_row = -1;
    int          bad_row = -1;
    int          hang_cycles = 0;
    int          done_cnt = 0;

    typedef struct {
        bit          sel;
        int          kind;      // 0: random table_i, 1: identity, 2: random
        logic [7:0]  err_mask;
        bit          stalls;
        logic        exp_err;
        logic [2:0]  exp_row;
        bit          chk_const;
        logic [31:0] row0;
        logic [31:0] row7;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int r);
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            w = w + ((32'(model_tbl[4*r + k]) & 32'h1F) << (8*k));
        end
        return w;
    endfunction

    function automatic int row_of(input logic [31:0] addr);
        return int'((addr - TB_BASE) >> 2) & 7;
    endfunction

    // Slave model at the falling edge: record the handshake from the last rising
    // edge, check request stability and busy, then set up the next response.
    always @(negedge clk_i) begin : bus_model
        int r;
        bit new_txn;
        if (!rst_n_i) begin
            p_req      = '0;
            p_ready    = 1'b0;
            stall_left = 0;
            rsp        = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
        end else begin
            if (p_req.valid && p_ready) begin
                hs_q.push_back(p_req);
                if (p_req.write) mem[row_of(p_req.addr)] = p_req.wdata;
                new_txn = 1'b1;
            end else begin
                new_txn = !p_req.valid;
                if (p_req.valid && req.valid) begin
                    check("stable addr", req.addr, p_req.addr);
                    check("stable wdata", req.wdata, p_req.wdata);
                end
            end
            if (req.valid) begin
                check("busy during request", 32'(busy_o), 32'd1);
                r = row_of(req.addr);
                if (new_txn) stall_left = stalls_en ? int'($urandom_range(0, 5)) : 0;
                if (r == hang_row) begin
                    hang_cycles++;
                    rsp.ready = 1'b0;
                end else if (stall_left > 0) begin
                    stall_left--;
                    rsp.ready = 1'b0;
                end else begin
                    rsp.ready = 1'b1;
                end
                rsp.error = err_mask[r];
                rsp.rdata = (r == bad_row) ? 32'h0 : mem[r];
            end else begin
                rsp = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
            end
            if (done_o) done_cnt++;
            p_req   = req;
            p_ready = rsp.ready;
        end
    end

    // Optionally pulse start at cycle 0, scramble table_i at mut_at, pulse start
    // again at extra_at; wait (bounded) for done_o and check it is one cycle wide.
    task automatic wait_done(input bit do_start, input int mut_at, input int extra_at,
                             input bit start_on_done, output int cycles);
        cycles = 0;
        while (done_o !== 1'b1 && cycles < 3000) begin
            if (cycles == mut_at) begin
                for (int j = 0; j < 32; j++) table_i[j] = 5'($urandom);
            end
            start_i = (do_start && cycles == 0) || (cycles == extra_at);
            @(negedge clk_i);
            cycles++;
        end
        start_i = start_on_done;
        check("done seen", 32'(done_o), 32'd1);
        @(negedge clk_i);
        start_i = 1'b0;
        check("done one cycle", 32'(done_o), 32'd0);
    endtask

    task automatic check_load(input string name, input int n_wr, input int n_rd,
                              input logic exp_err, input logic [2:0] exp_row);
        check({name, " handshakes"}, 32'(hs_q.size()), 32'(n_wr + n_rd));
        for (int i = 0; i < hs_q.size() && i < n_wr + n_rd; i++) begin
            if (i < n_wr) begin
                check($sformatf("%s wr%0d addr", name, i), hs_q[i].addr, TB_BASE + 32'(4*i));
                check($sformatf("%s wr%0d write", name, i), 32'(hs_q[i].write), 32'd1);
                check($sformatf("%s wr%0d wstrb", name, i), 32'(hs_q[i].wstrb), 32'hF);
                check($sformatf("%s wr%0d wdata", name, i), hs_q[i].wdata, exp_word(i));
            end else begin
                check($sformatf("%s rd%0d addr", name, i - n_wr), hs_q[i].addr, TB_BASE + 32'(4*(i - n_wr)));
                check($sformatf("%s rd%0d write", name, i - n_wr), 32'(hs_q[i].write), 32'd0);
                check($sformatf("%s rd%0d wstrb", name, i - n_wr), 32'(hs_q[i].wstrb), 32'h0);
            end
        end
        check({name, " error_o"}, 32'(error_o), 32'(exp_err));
        check({name, " err_row_o"}, 32'(err_row_o), 32'(exp_row));
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int cyc;
        v = vecs[idx];
        table_sel_i = v.sel;
        for (int j = 0; j < 32; j++) begin
            table_i[j]   = (v.kind == 1) ? 5'(j) : 5'($urandom);
            model_tbl[j] = v.sel ? int'(table_i[j]) : sbox_ref[j];
        end
        err_mask  = v.err_mask;
        stalls_en = v.stalls;
        hs_q.delete();
        done_cnt  = 0;
        wait_done(1'b1, 3, -1, 1'b0, cyc);
        if (!v.stalls) check($sformatf("vec%0d latency", idx), 32'(cyc), 32'(9 + N_READS));
        check_load($sformatf("vec%0d", idx), 8, N_READS, v.exp_err, v.exp_row);
        check($sformatf("vec%0d done count", idx), 32'(done_cnt), 32'd1);
        if (v.chk_const && hs_q.size() >= 8) begin
            check($sformatf("vec%0d row0 word", idx), hs_q[0].wdata, v.row0);
            check($sformatf("vec%0d row7 word", idx), hs_q[7].wdata, v.row7);
        end
    endtask

    initial begin
        int cyc;
        vecs[0] = '{sel: 1'b0, kind: 0, err_mask: 8'h00, stalls: 1'b0, exp_err: 1'b0, exp_row: 3'd0,
                    chk_const: 1'b1, row0: 32'h141F0B04, row7: 32'h170F0A16};
        vecs[1] = '{sel: 1'b1, kind: 1, err_mask: 8'h00, stalls: 1'b0, exp_err: 1'b0, exp_row: 3'd0,
                    chk_const: 1'b1, row0: 32'h03020100, row7: 32'h1F1E1D1C};
        vecs[2] = '{sel: 1'b1, kind: 2, err_mask: 8'h00, stalls: 1'b1, exp_err: 1'b0, exp_row: 3'd0,
                    chk_const: 1'b0, row0: 32'h0, row7: 32'h0};
        vecs[3] = '{sel: 1'b0, kind: 0, err_mask: 8'h28, stalls: 1'b0, exp_err: 1'b1, exp_row: 3'd3,
                    chk_const: 1'b0, row0: 32'h0, row7: 32'h0};
        vecs[4] = '{sel: 1'b1, kind: 2, err_mask: 8'h80, stalls: 1'b1, exp_err: 1'b1, exp_row: 3'd7,
                    chk_const: 1'b0, row0: 32'h0, row7: 32'h0};
        vecs[5] = '{sel: 1'b1, kind: 1, err_mask: 8'h41, stalls: 1'b1, exp_err: 1'b1, exp_row: 3'd0,
                    chk_const: 1'b1, row0: 32'h03020100, row7: 32'h1F1E1D1C};
        for (int j = 0; j < 8; j++) mem[j] = 32'h0;

        // Reset values.
        repeat (3) @(negedge clk_i);
        check("reset valid", 32'(req.valid), 32'd0);
        check("reset addr", req.addr, 32'h0);
        check("reset wdata", req.wdata, 32'h0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset error", 32'(error_o), 32'd0);
        check("reset err_row", 32'(err_row_o), 32'd0);

        // Automatic load after reset release, built-in table, ready tied high.
        for (int j = 0; j < 32; j++) model_tbl[j] = sbox_ref[j];
        hs_q.delete();
        done_cnt = 0;
        rst_n_i  = 1'b1;
        wait_done(1'b0, -1, -1, 1'b0, cyc);
        check("auto latency", 32'(cyc), 32'(9 + N_READS));
        check_load("auto", 8, N_READS, 1'b0, 3'd0);
        check("auto done count", 32'(done_cnt), 32'd1);
        if (hs_q.size() >= 8) begin
            check("auto row0 word", hs_q[0].wdata, 32'h141F0B04);
            check("auto row7 word", hs_q[7].wdata, 32'h170F0A16);
        end

        // Table-driven load scenarios.
        for (int i = 0; i < 6; i++) run_vec(i);

        // Start while busy and start during done_o are both ignored.
        table_sel_i = 1'b0;
        for (int j = 0; j < 32; j++) model_tbl[j] = sbox_ref[j];
        err_mask  = 8'h00;
        stalls_en = 1'b1;
        hs_q.delete();
        done_cnt  = 0;
        wait_done(1'b1, -1, 4, 1'b1, cyc);
        check_load("restart", 8, N_READS, 1'b0, 3'd0);
        repeat (4) @(negedge clk_i);
        check("restart busy idle", 32'(busy_o), 32'd0);
        check("restart valid idle", 32'(req.valid), 32'd0);
        check("restart no extra load", 32'(hs_q.size()), 32'(8 + N_READS));
        check("restart done count", 32'(done_cnt), 32'd1);

        // Row 2 never ready: timeout after TB_TMO cycles, rows 3-7 untouched.
        stalls_en   = 1'b0;
        hang_row    = 2;
        hang_cycles = 0;
        hs_q.delete();
        wait_done(1'b1, -1, -1, 1'b0, cyc);
        hang_row = -1;
        check_load("timeout", 2, 0, 1'b1, 3'd2);
        check("timeout valid cycles", 32'(hang_cycles), 32'(TB_TMO));

`ifdef ASCON_SBOX_LOADER_VERIFY_EN
        // Read-back of row 4 returns zero.
        bad_row = 4;
        hs_q.delete();
        wait_done(1'b1, -1, -1, 1'b0, cyc);
        bad_row = -1;
        check_load("verify bad row", 8, N_READS, 1'b1, 3'd4);
`endif

        // Reset in the middle of a load after an error has been flagged.
        err_mask = 8'h02;
        hs_q.delete();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("pre-reset error", 32'(error_o), 32'd1);
        check("pre-reset err_row", 32'(err_row_o), 32'd1);
        check("pre-reset busy", 32'(busy_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        check("async reset valid", 32'(req.valid), 32'd0);
        check("async reset addr", req.addr, 32'h0);
        check("async reset busy", 32'(busy_o), 32'd0);
        check("async reset error", 32'(error_o), 32'd0);
        check("async reset err_row", 32'(err_row_o), 32'd0);
        repeat (2) @(negedge clk_i);
        err_mask = 8'h00;
        hs_q.delete();
        done_cnt = 0;
        rst_n_i  = 1'b1;
        wait_done(1'b0, -1, -1, 1'b0, cyc);
        check("post-reset latency", 32'(cyc), 32'(9 + N_READS));
        check_load("post-reset", 8, N_READS, 1'b0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
